// File: rtl/multicycle_control_fsm.sv
// Multicycle processor main controller: Moore FSM that sequences the shared
// datapath (PC, unified memory, register file, ALU, result mux) over several
// cycles per instruction, with combinational ALU and immediate-type decoders.
// Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
module multicycle_control_fsm #(
  parameter logic TRAP_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state;
  state_t dec_state;
  aluop_t alu_op;
  logic   op_legal;
  logic   pc_update;
  logic   branch;
  logic   ir_write;
  logic   mem_write;
  logic   reg_write;

  // Opcode recognition shared by the next-state logic and illegal_op
  always_comb begin
    op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  end

  // State register and next-state sequencing; HALT is left only via reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if ((op == OP_LW) || (op == OP_SW)) state <= S_MEMADR;
          else if (op == OP_R)                state <= S_EXECR;
          else if (op == OP_I)                state <= S_EXECI;
          else if (op == OP_BEQ)              state <= S_BEQ;
          else if (op == OP_JAL)              state <= S_JAL;
          else if (TRAP_ILLEGAL)              state <= S_HALT;
          else                                state <= S_FETCH;
        end
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state <= S_MEMWB;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= S_FETCH;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of selects and raw strobes; reset presents the FETCH decode
  always_comb begin
    dec_state = reset ? S_FETCH : state;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (dec_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_HALT: begin
      end
      default: begin
      end
    endcase
  end

  // Write strobes are suppressed for the whole reset cycle; branch uses live zero
  always_comb begin
    PCWrite    = ~reset & (pc_update | (branch & zero));
    IRWrite    = ~reset & ir_write;
    MemWrite   = ~reset & mem_write;
    RegWrite   = ~reset & reg_write;
    illegal_op = ~reset & (state == S_DECODE) & ~op_legal;
  end

  // ALU decoder: op[5] separates R-type sub from I-type addi
  always_comb begin
    case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (non-trapping and trapping)
// share one stimulus stream; an instruction-level model predicts both.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  logic       pcw [2];
  logic       adr [2];
  logic       mw  [2];
  logic       irw [2];
  logic [1:0] rs  [2];
  logic [1:0] sa  [2];
  logic [1:0] sb  [2];
  logic [2:0] aluc[2];
  logic [1:0] imm [2];
  logic       rw  [2];
  logic       ill [2];
  logic [3:0] st  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TRAP_ILLEGAL(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemWrite(mw[0]),
    .IRWrite(irw[0]), .ResultSrc(rs[0]), .ALUSrcA(sa[0]), .ALUSrcB(sb[0]),
    .ALUControl(aluc[0]), .ImmSrc(imm[0]), .RegWrite(rw[0]),
    .illegal_op(ill[0]), .state_dbg(st[0]));

  multicycle_control_fsm #(.TRAP_ILLEGAL(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemWrite(mw[1]),
    .IRWrite(irw[1]), .ResultSrc(rs[1]), .ALUSrcA(sa[1]), .ALUSrcB(sb[1]),
    .ALUControl(aluc[1]), .ImmSrc(imm[1]), .RegWrite(rw[1]),
    .illegal_op(ill[1]), .state_dbg(st[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, d, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BEQ) || (o == JAL);
  endfunction

  // Cycle count of one instruction from FETCH entry
  function automatic int seq_len(input logic [6:0] o);
    case (o)
      LW:      return 5;
      SW:      return 4;
      RT:      return 4;
      IT:      return 4;
      BEQ:     return 3;
      JAL:     return 4;
      default: return 2;
    endcase
  endfunction

  // State visited on a given cycle of an instruction
  function automatic int seq_state(input logic [6:0] o, input int k);
    int lw_s[5]  = '{0, 1, 2, 3, 4};
    int sw_s[4]  = '{0, 1, 2, 5};
    int r_s[4]   = '{0, 1, 6, 8};
    int i_s[4]   = '{0, 1, 7, 8};
    int beq_s[3] = '{0, 1, 9};
    int jal_s[4] = '{0, 1, 10, 8};
    case (o)
      LW:      return lw_s[k];
      SW:      return sw_s[k];
      RT:      return r_s[k];
      IT:      return i_s[k];
      BEQ:     return beq_s[k];
      JAL:     return jal_s[k];
      default: return k;
    endcase
  endfunction

  typedef struct packed {
    logic       adr, irw, mw, rw, pcu, br;
    logic [1:0] rs, sa, sb, aop;   // aop: 0 add, 1 sub, 2 funct
  } ctrl_t;

  // Control word of each state as listed in the state table
  function automatic ctrl_t ctrl_of(input int s);
    ctrl_t c = '0;
    case (s)
      0:  begin c.irw = 1; c.sb = 2; c.rs = 2; c.pcu = 1; end
      1:  begin c.sa = 1; c.sb = 1; end
      2:  begin c.sa = 2; c.sb = 1; end
      3:  begin c.adr = 1; end
      4:  begin c.rs = 1; c.rw = 1; end
      5:  begin c.adr = 1; c.mw = 1; end
      6:  begin c.sa = 2; c.aop = 2; end
      7:  begin c.sa = 2; c.sb = 1; c.aop = 2; end
      8:  begin c.rw = 1; end
      9:  begin c.sa = 2; c.aop = 1; c.br = 1; end
      10: begin c.sa = 1; c.sb = 2; c.pcu = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_of(input logic [1:0] aop, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7);
    if (aop == 0) return 3'b000;
    if (aop == 1) return 3'b001;
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  bit m_valid = 0;
  int m_step[2] = '{0, 0};
  bit m_halt[2] = '{0, 0};

  // Advance the model on each edge: reset restarts, otherwise step through the instruction
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      for (int d = 0; d < 2; d++) begin m_step[d] = 0; m_halt[d] = 0; end
    end else if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        if (!m_halt[d]) begin
          m_step[d]++;
          if (m_step[d] == seq_len(op)) begin
            m_step[d] = 0;
            if (d == 1 && !is_legal(op)) m_halt[d] = 1;
          end
        end
      end
    end
  end

  // Compare every output of both instances mid-cycle
  always @(negedge clk) begin
    int s;
    ctrl_t c;
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        s = m_halt[d] ? 11 : seq_state(op, m_step[d]);
        c = ctrl_of(reset ? 0 : s);
        chk("state_dbg", d, 32'(st[d]), 32'(s));
        chk("PCWrite", d, 32'(pcw[d]), 32'(!reset && (c.pcu || (c.br && zero))));
        chk("IRWrite", d, 32'(irw[d]), 32'(!reset && c.irw));
        chk("MemWrite", d, 32'(mw[d]), 32'(!reset && c.mw));
        chk("RegWrite", d, 32'(rw[d]), 32'(!reset && c.rw));
        chk("AdrSrc", d, 32'(adr[d]), 32'(c.adr));
        chk("ResultSrc", d, 32'(rs[d]), 32'(c.rs));
        chk("ALUSrcA", d, 32'(sa[d]), 32'(c.sa));
        chk("ALUSrcB", d, 32'(sb[d]), 32'(c.sb));
        chk("ALUControl", d, 32'(aluc[d]), 32'(alu_of(c.aop, op, funct3, funct7b5)));
        chk("ImmSrc", d, 32'(imm[d]), 32'(imm_of(op)));
        chk("illegal_op", d, 32'(ill[d]), 32'(!reset && s == 1 && !is_legal(op)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_in(input logic r, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z);
    @(posedge clk);
    #1;
    reset = r; op = o; funct3 = f3; funct7b5 = f7; zero = z;
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] o;
    int k;
    // Reset held two cycles
    step_in(1, LW, 3'b000, 0, 0);
    chk("lit_rst_pcw", 0, 32'(pcw[0]), 0);
    chk("lit_rst_irw", 0, 32'(irw[0]), 0);
    step_in(1, LW, 3'b000, 0, 0);
    chk("lit_rst_rw", 1, 32'(rw[1]), 0);
    // lw: states 0..4
    step_in(0, LW, 3'b000, 0, 0);
    chk("lit_first_st", 0, 32'(st[0]), 0);
    chk("lit_first_pcw", 0, 32'(pcw[0]), 1);
    chk("lit_first_irw", 0, 32'(irw[0]), 1);
    for (int i = 1; i <= 4; i++) begin
      step_in(0, LW, 3'b000, 0, 0);
      chk("lit_lw_st", 0, 32'(st[0]), 32'(i));
      chk("lit_lw_mw", 0, 32'(mw[0]), 0);
    end
    chk("lit_lw_rw", 0, 32'(rw[0]), 1);
    chk("lit_lw_rs", 0, 32'(rs[0]), 1);
    // sw: states 0,1,2,5
    step_in(0, SW, 3'b010, 0, 0);
    step_in(0, SW, 3'b010, 0, 0);
    chk("lit_sw_imm", 0, 32'(imm[0]), 1);
    step_in(0, SW, 3'b010, 0, 0);
    step_in(0, SW, 3'b010, 0, 0);
    chk("lit_sw_st", 0, 32'(st[0]), 5);
    chk("lit_sw_mw", 0, 32'(mw[0]), 1);
    chk("lit_sw_adr", 0, 32'(adr[0]), 1);
    // R-type sub, and, slt
    step_in(0, RT, 3'b000, 1, 0);
    step_in(0, RT, 3'b000, 1, 0);
    step_in(0, RT, 3'b000, 1, 0);
    chk("lit_sub_st", 0, 32'(st[0]), 6);
    chk("lit_sub_alu", 0, 32'(aluc[0]), 32'h1);
    step_in(0, RT, 3'b000, 1, 0);
    chk("lit_aluwb_st", 0, 32'(st[0]), 8);
    for (int i = 0; i < 2; i++) begin
      o = RT;
      k = (i == 0) ? 7 : 2;
      step_in(0, o, 3'(k), 0, 0);
      step_in(0, o, 3'(k), 0, 0);
      step_in(0, o, 3'(k), 0, 0);
      chk("lit_rt_alu", 0, 32'(aluc[0]), (i == 0) ? 32'h2 : 32'h5);
      step_in(0, o, 3'(k), 0, 0);
    end
    // beq taken then not taken
    for (int i = 0; i < 2; i++) begin
      step_in(0, BEQ, 3'b000, 0, 0);
      step_in(0, BEQ, 3'b000, 0, 0);
      step_in(0, BEQ, 3'b000, 0, (i == 0));
      chk("lit_beq_st", 0, 32'(st[0]), 9);
      chk("lit_beq_pcw", 0, 32'(pcw[0]), (i == 0) ? 1 : 0);
    end
    // Illegal opcode
    step_in(0, 7'b0000000, 3'b000, 0, 0);
    chk("lit_beq_next", 0, 32'(st[0]), 0);
    step_in(0, 7'b0000000, 3'b000, 0, 0);
    chk("lit_ill0", 0, 32'(ill[0]), 1);
    chk("lit_ill1", 1, 32'(ill[1]), 1);
    step_in(0, 7'b0000000, 3'b000, 0, 0);
    chk("lit_notrap_st", 0, 32'(st[0]), 0);
    chk("lit_trap_st", 1, 32'(st[1]), 11);
    chk("lit_ill_once", 0, 32'(ill[0]), 0);
    step_in(0, 7'b0000000, 3'b000, 0, 0);
    chk("lit_trap_hold", 1, 32'(st[1]), 11);
    step_in(1, LW, 3'b000, 0, 0);
    step_in(0, LW, 3'b000, 0, 0);
    chk("lit_trap_rst", 1, 32'(st[1]), 0);
    // Reset during MEMREAD
    step_in(0, LW, 3'b000, 0, 0);
    step_in(0, LW, 3'b000, 0, 0);
    step_in(1, LW, 3'b000, 0, 0);
    chk("lit_memread_st", 0, 32'(st[0]), 3);
    step_in(0, LW, 3'b000, 0, 0);
    chk("lit_midrst_st", 0, 32'(st[0]), 0);
    chk("lit_midrst_rw", 0, 32'(rw[0]), 0);

    // Randomized instruction stream with occasional resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 39) == 0);
      zero  = 1'($urandom_range(0, 1));
      if (m_step[0] == 0) begin
        k = $urandom_range(0, 6);
        case (k)
          0: o = LW;
          1: o = SW;
          2: o = RT;
          3: o = IT;
          4: o = BEQ;
          5: o = JAL;
          default: begin
            o = 7'($urandom_range(0, 127));
            while (is_legal(o)) o = 7'($urandom_range(0, 127));
          end
        endcase
        op = o;
        funct3 = 3'($urandom_range(0, 7));
        funct7b5 = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
